// File: rtl/instruction_fetch_if.sv
// Instruction-memory read port between the fetch stage (master) and instruction memory (slave).
// Handshake: MemReq stays high with MemAddr stable until the memory returns MemAck=1
// together with MemData in the same cycle; MemAck while MemReq is low carries no meaning.
interface instruction_fetch_if #(
   parameter int ADDR_W = 32
);
   logic              MemReq;
   logic [ADDR_W-1:0] MemAddr;
   logic              MemAck;
   logic [31:0]       MemData;

   modport master (
      output MemReq,
      output MemAddr,
      input  MemAck,
      input  MemData
   );

   modport slave (
      input  MemReq,
      input  MemAddr,
      output MemAck,
      output MemData
   );
endinterface

// File: rtl/instruction_fetch.sv
// MIPS fetch stage: samples the PC, reads instruction memory over req/ack, holds and decodes the IR.
// Optional REQ timeout (aborts to a NOP with a sticky FetchError) is built when FETCH_TIMEOUT_EN is defined.
module instruction_fetch #(
   parameter int ADDR_W = 32
`ifdef FETCH_TIMEOUT_EN
   ,
   parameter int TIMEOUT = 16
`endif
) (
   input  logic                Clk,
   input  logic                Reset,
   input  logic [ADDR_W-1:0]   PresentState,
   input  logic                Stall,
   input  logic                Flush,
   instruction_fetch_if.master mem,
   output logic                PcEnable,
   output logic                InstrValid,
   output logic [31:0]         Instruction,
   output logic [5:0]          OpCode,
   output logic [4:0]          Rs,
   output logic [4:0]          Rt,
   output logic [4:0]          Rd,
   output logic [4:0]          Shamt,
   output logic [5:0]          Funct,
   output logic [15:0]         Address,
   output logic [25:0]         Target,
   output logic                FetchError,
   output logic [1:0]          o_dbg_state
);

   // o_dbg_state encoding: 0 IDLE, 1 REQ, 2 VALID
   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_REQ   = 2'd1,
      S_VALID = 2'd2
   } state_t;

   state_t            r_state;
   state_t            w_nxt_state;
   logic              r_mem_req;
   logic [ADDR_W-1:0] r_mem_addr;
   logic [ADDR_W-1:0] w_nxt_addr;
   logic [31:0]       r_ir;
   logic [31:0]       w_nxt_ir;
   logic              r_valid;
   logic              r_pc_en;
   logic              w_nxt_pc_en;
   logic              w_timeout;

   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset) begin
         r_state    <= S_IDLE;
         r_mem_req  <= 1'b0;
         r_mem_addr <= '0;
         r_ir       <= '0;
         r_valid    <= 1'b0;
         r_pc_en    <= 1'b0;
      end else begin
         r_state    <= w_nxt_state;
         r_mem_req  <= (w_nxt_state == S_REQ);
         r_valid    <= (w_nxt_state == S_VALID);
         r_pc_en    <= w_nxt_pc_en;
         r_mem_addr <= w_nxt_addr;
         r_ir       <= w_nxt_ir;
      end
   end

   // Flush beats ack/timeout, which beat Stall.
   always_comb begin
      w_nxt_state = r_state;
      if (Flush) begin
         w_nxt_state = S_IDLE;
      end else begin
         case (r_state)
            S_IDLE:  if (!Stall) w_nxt_state = S_REQ;
            S_REQ:   if (mem.MemAck || w_timeout) w_nxt_state = S_VALID;
            S_VALID: if (!Stall) w_nxt_state = S_IDLE;
            default: w_nxt_state = S_IDLE;
         endcase
      end
   end

   always_comb begin
      w_nxt_addr  = r_mem_addr;
      w_nxt_ir    = r_ir;
      w_nxt_pc_en = 1'b0;
      if (!Flush) begin
         if (r_state == S_IDLE && !Stall) begin
            w_nxt_addr = PresentState;
         end
         if (r_state == S_REQ && mem.MemAck) begin
            w_nxt_ir    = mem.MemData;
            w_nxt_pc_en = 1'b1;
         end else if (w_timeout) begin
            w_nxt_ir = '0;
         end
      end
   end

`ifdef FETCH_TIMEOUT_EN
   logic [7:0] r_cnt;
   logic       r_err;

   // An ack on the terminal count wins, so the abort only fires on a silent REQ cycle.
   assign w_timeout = !Flush && (r_state == S_REQ) && !mem.MemAck
                      && (r_cnt == 8'(TIMEOUT - 1));

   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset) begin
         r_cnt <= 8'd0;
         r_err <= 1'b0;
      end else begin
         r_cnt <= (r_state == S_REQ && w_nxt_state == S_REQ) ? r_cnt + 8'd1 : 8'd0;
         r_err <= r_err | w_timeout;
      end
   end

   assign FetchError = r_err;
`else
   assign w_timeout  = 1'b0;
   assign FetchError = 1'b0;
`endif

   assign mem.MemReq  = r_mem_req;
   assign mem.MemAddr = r_mem_addr;
   assign PcEnable    = r_pc_en;
   assign InstrValid  = r_valid;
   assign Instruction = r_ir;
   assign o_dbg_state = r_state;

   assign OpCode  = r_ir[31:26];
   assign Rs      = r_ir[25:21];
   assign Rt      = r_ir[20:16];
   assign Rd      = r_ir[15:11];
   assign Shamt   = r_ir[10:6];
   assign Funct   = r_ir[5:0];
   assign Address = r_ir[15:0];
   assign Target  = r_ir[25:0];

endmodule

// File: doc/instruction_fetch.md
# instruction_fetch

Fetch stage that sits directly downstream of the MIPS program counter. It samples the PC value (`PresentState`) and issues a read to instruction memory over a req/ack handshake. It latches the returned word into an instruction register (IR) and decodes its R/I/J fields. It also returns a one-cycle `PcEnable` pulse so the program counter advances only after an instruction has been accepted.

## Interface
- `ADDR_W`, 32: width of PC and memory address.
- `TIMEOUT`, 16: maximum REQ cycles before abort (range 2..255); used only with `FETCH_TIMEOUT_EN`.

Ports:
- `Clk` in 1: single clock, rising edge.
- `Reset` in 1: asynchronous, active-low reset.
- `PresentState` in ADDR_W: current PC from the program counter.
- `Stall` in 1: downstream not ready; hold the current instruction.
- `Flush` in 1: discard any in-flight or held fetch (taken branch or jump).
- `MemReq` out 1: instruction memory read request.
- `MemAddr` out ADDR_W: read address, registered.
- `MemAck` in 1: read data valid this cycle.
- `MemData` in 32: instruction word.
- `PcEnable` out 1: one-cycle pulse that lets the program counter load its next state.
- `InstrValid` out 1: IR holds a valid instruction.
- `Instruction` out 32: IR contents.
- `OpCode` out 6: IR[31:26].
- `Rs` out 5: IR[25:21].
- `Rt` out 5: IR[20:16].
- `Rd` out 5: IR[15:11].
- `Shamt` out 5: IR[10:6].
- `Funct` out 6: IR[5:0].
- `Address` out 16: IR[15:0].
- `Target` out 26: IR[25:0].
- `FetchError` out 1: sticky timeout flag.

## Operation
- FSM states: IDLE, REQ, VALID.
- Reset (`Reset`=0):
  - State goes to IDLE immediately (asynchronous).
  - IR, `MemAddr`, the timeout counter and all outputs clear to 0.
  - IR=0 decodes as `sll $0,$0,0`, i.e. a NOP.
- IDLE:
  - If `Stall`=0: `MemAddr`<=`PresentState`; next state REQ.
  - If `Stall`=1: remain in IDLE.
- REQ:
  - `MemReq`=1 for every cycle in REQ; `MemAddr` is held stable.
  - On `MemAck`=1: IR<=`MemData`, `InstrValid`<=1, `PcEnable`<=1; next state VALID.
- VALID:
  - `InstrValid`=1, and `PcEnable` is high only in the first VALID cycle.
  - If `Stall`=1: remain in VALID; IR is frozen.
  - If `Stall`=0: next state IDLE; `InstrValid`<=0.
- Decode fields are combinational slices of IR. They are always driven, including when `InstrValid`=0.
- Priority: `Flush` > `MemAck`/timeout > `Stall`.
- `Flush`=1 in any state:
  - Next state is IDLE; `InstrValid`<=0; `PcEnable`<=0; counter clears.
  - IR is left unchanged, and `MemData` is discarded even if `MemAck`=1 in the same cycle.
- `MemAck` outside REQ is ignored.
- `PresentState` is sampled only in IDLE, so the program counter may change freely at any other time.

## Timing
- `MemReq` rises on the clock edge after IDLE samples the PC.
- A `MemAck` in the first REQ cycle is legal (zero wait states).
- Latency with zero-wait memory and no stall:
  - Cycle 0: IDLE, address sampled.
  - Cycle 1: REQ, ack.
  - Cycle 2: VALID and `PcEnable`=1.
  - Cycle 3: IDLE, which samples the PC that has already advanced.
  - Throughput: one instruction per 3 cycles; each wait state adds 1 cycle.
- `PcEnable` is exactly one cycle per accepted instruction and is never asserted twice for one fetch.
- All outputs are registered except the decode fields, which are IR slices.
- Asserting `Reset` mid-REQ drops `MemReq` within the same cycle (asynchronous); the memory's pending ack is ignored.

## Configuration
- `FETCH_TIMEOUT_EN` defined:
  - An 8-bit counter increments on each REQ cycle without `MemAck`.
  - When the counter reaches `TIMEOUT`-1 without an ack: IR<=0 (NOP), `InstrValid`<=1, `PcEnable` stays 0, `FetchError`<=1 (sticky until reset); next state VALID.
  - An ack arriving on that same cycle wins over the timeout.
- `FETCH_TIMEOUT_EN` undefined: REQ waits indefinitely, no counter logic is built, and `FetchError` is tied to 0.

## Test plan
- Basic fetch:
  - Stimulus: release `Reset` with `PresentState`=0x00400000; `MemAck`=1 with `MemData`=0x10004321 in the first REQ cycle.
  - Required: `MemAddr`=0x00400000; `OpCode`=000100, `Rs`=0, `Rt`=0, `Address`=0x4321, `InstrValid`=1; `PcEnable` is a single pulse in cycle 2.
- Wait states:
  - Stimulus: `MemAck` arrives after 5 REQ cycles with `MemData`=0x8C220004.
  - Required: `MemReq` high for 6 cycles with `MemAddr` stable; `OpCode`=100011, `Rs`=1, `Rt`=2, `Address`=0x0004; exactly one `PcEnable` pulse.
- Stall hold:
  - Stimulus: `Stall`=1 for 4 cycles while in VALID.
  - Required: `Instruction` unchanged, `InstrValid`=1, no `MemReq`, `PcEnable` pulsed only once; fetch resumes in the cycle after `Stall` drops.
- Flush collision:
  - Stimulus: `Flush`=1 and `MemAck`=1 in the same REQ cycle.
  - Required: IR keeps its old value, `InstrValid`=0, `PcEnable`=0; next state IDLE, with `MemReq` low on the next cycle.
- Timeout (`FETCH_TIMEOUT_EN` defined, `TIMEOUT`=8):
  - Stimulus: `MemAck` is never asserted.
  - Required: after 8 REQ cycles, `FetchError`=1, `Instruction`=0, `InstrValid`=1, `PcEnable`=0; `FetchError` remains 1 until `Reset`.
- Reset mid-request:
  - Stimulus: drive `Reset` low during the third REQ cycle.
  - Required: `MemReq`, `InstrValid`, `PcEnable` and `Instruction` all 0 before the next clock edge.
